// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory, feeds IF/ID.
// Optional FETCH_PERF_CNT_EN adds StallCycles/FetchCount counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemRdy,
    input  logic [31:0] ImemData,
    output logic [31:0] NewPCAddress,
    output logic [31:0] Instruction,
    output logic        IF_ID_En,
    output logic        IF_ID_Flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FetchCount
`endif
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_hold_instr, w_hold_instr_nxt;
    logic [31:0] r_hold_npc, w_hold_npc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_npc, w_npc_nxt;
    logic        r_en, w_en_nxt;
    logic        r_flush, w_flush_nxt;
    logic [31:0] w_pc_inc;
    logic [31:0] w_redir_pc;

    assign w_pc_inc   = r_pc + PC_INC;
    assign w_redir_pc = RedirectPC & ~32'h3;

    assign ImemReq      = (r_state == S_FETCH);
    assign ImemAddr     = r_pc;
    assign NewPCAddress = r_npc;
    assign Instruction  = r_instr;
    assign IF_ID_En     = r_en;
    assign IF_ID_Flush  = r_flush;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_npc_nxt   = r_hold_npc;
        w_instr_nxt      = r_instr;
        w_npc_nxt        = r_npc;
        w_en_nxt         = 1'b0;
        w_flush_nxt      = 1'b0;
        if (Redirect) begin
            // Redirect wins over stall and drops whatever memory returned this cycle.
            w_state_nxt = S_FETCH;
            w_pc_nxt    = w_redir_pc;
            w_flush_nxt = 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (ImemRdy) begin
                        w_pc_nxt = w_pc_inc;
                        if (Stall) begin
                            w_hold_instr_nxt = ImemData;
                            w_hold_npc_nxt   = w_pc_inc;
                            w_state_nxt      = S_HOLD;
                        end else begin
                            w_instr_nxt = ImemData;
                            w_npc_nxt   = w_pc_inc;
                            w_en_nxt    = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        w_instr_nxt = r_hold_instr;
                        w_npc_nxt   = r_hold_npc;
                        w_en_nxt    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_hold_instr <= 32'd0;
            r_hold_npc   <= 32'd0;
            r_instr      <= 32'd0;
            r_npc        <= 32'd0;
            r_en         <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_npc   <= w_hold_npc_nxt;
            r_instr      <= w_instr_nxt;
            r_npc        <= w_npc_nxt;
            r_en         <= w_en_nxt;
            r_flush      <= w_flush_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_stall_cycle;
    assign w_stall_cycle = (r_state == S_HOLD) || !ImemRdy;

    // FetchCount moves in the same cycle IF_ID_En rises, so both are aligned.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCycles <= 32'd0;
            FetchCount  <= 32'd0;
        end else begin
            if (w_stall_cycle && (StallCycles != 32'hFFFF_FFFF))
                StallCycles <= StallCycles + 32'd1;
            if (w_en_nxt && (FetchCount != 32'hFFFF_FFFF))
                FetchCount <= FetchCount + 32'd1;
        end
    end
`endif

endmodule
